// File: rtl/reg_file_pkg.sv
// Shared core constants: register-file and ROB widths used across the core.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// The defaults here are the widths the rest of the core is built with. Modules
// that take them as parameters use these values as their defaults.
package reg_file_pkg;

  // Architectural register index width (32 registers).
  localparam int DEF_REG_NUM_WIDTH  = 5;

  // ROB entry index width. Rename tags carry one extra MSB that marks "no
  // pending producer", so a tag is DEF_ROB_SIZE_WIDTH+1 bits wide.
  localparam int DEF_ROB_SIZE_WIDTH = 5;

  // Width of an architectural register value.
  localparam int REG_DATA_WIDTH     = 32;

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags (issue renames, commit writes).
// Latency: operand reads are combinational; writes, renames and flush land on the next clk_in edge.
// Backpressure: none; rdy_in low freezes all state, the decoder owns the ROB-full stall.
//
// Ports:
//   clk_in, rst_in, rdy_in        clock, synchronous active-high reset, global enable
//   flush_in                      pipeline flush: every tag returns to NO_DEP
//   rob_valid/rob_rd/rob_value/rob_dependency
//                                 commit of a register-writing ROB entry
//   dec_valid/dec_rd/dec_rob_id   rename of a destination register at issue
//   rs1_in/rs2_in                 operand read addresses
//   val1_out/val2_out             operand values
//   dep1_out/dep2_out             pending producer tag, NO_DEP when the value is ready
module reg_file
  import reg_file_pkg::*;
#(
  parameter int REG_NUM_WIDTH  = DEF_REG_NUM_WIDTH,
  parameter int ROB_SIZE_WIDTH = DEF_ROB_SIZE_WIDTH
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          flush_in,

  input  logic                          rob_valid,
  input  logic [REG_NUM_WIDTH-1:0]      rob_rd,
  input  logic [REG_DATA_WIDTH-1:0]     rob_value,
  input  logic [ROB_SIZE_WIDTH:0]       rob_dependency,

  input  logic                          dec_valid,
  input  logic [REG_NUM_WIDTH-1:0]      dec_rd,
  input  logic [ROB_SIZE_WIDTH-1:0]     dec_rob_id,

  input  logic [REG_NUM_WIDTH-1:0]      rs1_in,
  input  logic [REG_NUM_WIDTH-1:0]      rs2_in,
  output logic [REG_DATA_WIDTH-1:0]     val1_out,
  output logic [REG_DATA_WIDTH-1:0]     val2_out,
  output logic [ROB_SIZE_WIDTH:0]       dep1_out,
  output logic [ROB_SIZE_WIDTH:0]       dep2_out
);

  localparam int NUM_REGS  = 1 << REG_NUM_WIDTH;
  localparam int TAG_WIDTH = ROB_SIZE_WIDTH + 1;

  // MSB set with a zero index: can never equal a real tag, because real tags
  // are built by zero-extending the ROB index.
  localparam logic [TAG_WIDTH-1:0] NO_DEP = {1'b1, {ROB_SIZE_WIDTH{1'b0}}};

  typedef struct packed {
    logic [REG_DATA_WIDTH-1:0] val;
    logic [TAG_WIDTH-1:0]      dep;
  } rd_port_t;

  // x0 has no storage: it is hardwired to 0/NO_DEP in the read path, so the
  // arrays start at index 1.
  logic [REG_DATA_WIDTH-1:0] value_q [1:NUM_REGS-1];
  logic [TAG_WIDTH-1:0]      dep_q   [1:NUM_REGS-1];

  logic                 commit_en;
  logic                 rename_en;
  logic [TAG_WIDTH-1:0] rename_tag;

  assign commit_en  = rob_valid && (rob_rd != '0);
  // A rename in a flush cycle belongs to a squashed instruction; drop it.
  assign rename_en  = dec_valid && (dec_rd != '0) && !flush_in;
  assign rename_tag = {1'b0, dec_rob_id};

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  // Per-register priority on dep: reset > flush > rename > commit-clear.
  // The value write is independent of the tag outcome: a commit always lands,
  // including in its own flush cycle (e.g. a JALR link register).
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        dep_q[i]   <= NO_DEP;
      end
    end else if (rdy_in) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (commit_en && (rob_rd == REG_NUM_WIDTH'(i))) begin
          value_q[i] <= rob_value;
        end

        if (flush_in) begin
          dep_q[i] <= NO_DEP;
        end else if (rename_en && (dec_rd == REG_NUM_WIDTH'(i))) begin
          dep_q[i] <= rename_tag;
        end else if (commit_en && (rob_rd == REG_NUM_WIDTH'(i)) &&
                     (dep_q[i] == rob_dependency)) begin
          // Only the most recent producer may mark the register ready; an
          // older commit with a stale tag leaves the younger rename in place.
          dep_q[i] <= NO_DEP;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand reads
  // ---------------------------------------------------------------------------
  // Reads see pre-edge state plus the same-cycle commit bypass. A same-cycle
  // rename is deliberately not visible: the issuing instruction must depend on
  // the previous producer of its own destination (add x1,x1,x2).
  // The bypass needs the tag match so that a stale commit cannot expose an
  // older value as ready while a younger producer is still in flight.
  function automatic rd_port_t read_port(input logic [REG_NUM_WIDTH-1:0] rs);
    rd_port_t r;
    r.val = '0;
    r.dep = NO_DEP;
    if (rs != '0) begin
      if (rob_valid && (rob_rd == rs) && (rob_dependency == dep_q[rs])) begin
        r.val = rob_value;
      end else begin
        r.val = value_q[rs];
        r.dep = dep_q[rs];
      end
    end
    return r;
  endfunction

  rd_port_t rd1;
  rd_port_t rd2;

  assign rd1      = read_port(rs1_in);
  assign rd2      = read_port(rs2_in);

  assign val1_out = rd1.val;
  assign dep1_out = rd1.dep;
  assign val2_out = rd2.val;
  assign dep2_out = rd2.dep;

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, rename/commit with bypass, stale commit,
// same-cycle commit+rename, flush, x0 handling and rdy_in hold.
// Inputs change #1 after posedge; outputs are sampled before the next edge.
module tb_reg_file;

  localparam logic [5:0] NO_DEP = 6'h20;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic        rob_valid;
  logic [4:0]  rob_rd;
  logic [31:0] rob_value;
  logic [5:0]  rob_dependency;
  logic        dec_valid;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rob_id;
  logic [4:0]  rs1_in, rs2_in;
  logic [31:0] val1_out, val2_out;
  logic [5:0]  dep1_out, dep2_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  reg_file dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .flush_in       (flush_in),
    .rob_valid      (rob_valid),
    .rob_rd         (rob_rd),
    .rob_value      (rob_value),
    .rob_dependency (rob_dependency),
    .dec_valid      (dec_valid),
    .dec_rd         (dec_rd),
    .dec_rob_id     (dec_rob_id),
    .rs1_in         (rs1_in),
    .rs2_in         (rs2_in),
    .val1_out       (val1_out),
    .val2_out       (val2_out),
    .dep1_out       (dep1_out),
    .dep2_out       (dep2_out)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    flush_in  = 1'b0;
    rob_valid = 1'b0;
    dec_valid = 1'b0;
    rob_rd = '0; rob_value = '0; rob_dependency = '0;
    dec_rd = '0; dec_rob_id = '0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [4:0] id);
    dec_valid = 1'b1; dec_rd = rd; dec_rob_id = id;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rdy_in = 1'b1; rst_in = 1'b1; idle();
    rs1_in = 5'd5; rs2_in = 5'd0;
    tick(); tick();
    rst_in = 1'b0;
    #1;
    checks++; if (val1_out !== 32'h0) begin failures++; $display("FAIL reset_val x5: got %h want %h", val1_out, 32'h0); end
    checks++; if (dep1_out !== NO_DEP) begin failures++; $display("FAIL reset_dep x5: got %h want %h", dep1_out, NO_DEP); end
    checks++; if (dep2_out !== NO_DEP) begin failures++; $display("FAIL reset_dep x0: got %h want %h", dep2_out, NO_DEP); end
  endtask

  task automatic test_rename_commit();
    rename(5'd3, 5'd7);
    rs1_in = 5'd3; rs2_in = 5'd3;
    #1;
    checks++; if (dep1_out !== 6'h07) begin failures++; $display("FAIL rename_dep x3: got %h want %h", dep1_out, 6'h07); end
    // same-cycle commit: bypass on both ports
    rob_valid = 1'b1; rob_rd = 5'd3; rob_dependency = 6'h07; rob_value = 32'hDEADBEEF;
    #1;
    checks++; if (val1_out !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_val1: got %h want %h", val1_out, 32'hDEADBEEF); end
    checks++; if (dep1_out !== NO_DEP) begin failures++; $display("FAIL bypass_dep1: got %h want %h", dep1_out, NO_DEP); end
    checks++; if (val2_out !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_val2: got %h want %h", val2_out, 32'hDEADBEEF); end
    tick(); idle(); #1;
    checks++; if (val1_out !== 32'hDEADBEEF) begin failures++; $display("FAIL commit_val x3: got %h want %h", val1_out, 32'hDEADBEEF); end
    checks++; if (dep2_out !== NO_DEP) begin failures++; $display("FAIL commit_dep x3: got %h want %h", dep2_out, NO_DEP); end
  endtask

  task automatic test_stale_commit();
    rename(5'd4, 5'd2);
    rename(5'd4, 5'd9);
    rs1_in = 5'd4; rs2_in = 5'd4;
    rob_valid = 1'b1; rob_rd = 5'd4; rob_dependency = 6'h02; rob_value = 32'h11;
    #1;
    // tag mismatch: no bypass, old value with younger tag
    checks++; if (val1_out !== 32'h0) begin failures++; $display("FAIL stale_nobypass_val: got %h want %h", val1_out, 32'h0); end
    checks++; if (dep1_out !== 6'h09) begin failures++; $display("FAIL stale_nobypass_dep: got %h want %h", dep1_out, 6'h09); end
    tick(); idle(); #1;
    checks++; if (val1_out !== 32'h11) begin failures++; $display("FAIL stale_val x4: got %h want %h", val1_out, 32'h11); end
    checks++; if (dep2_out !== 6'h09) begin failures++; $display("FAIL stale_dep x4: got %h want %h", dep2_out, 6'h09); end
  endtask

  task automatic test_same_cycle();
    rename(5'd6, 5'd1);
    rs1_in = 5'd6; rs2_in = 5'd6;
    rob_valid = 1'b1; rob_rd = 5'd6; rob_dependency = 6'h01; rob_value = 32'h55;
    dec_valid = 1'b1; dec_rd = 5'd6; dec_rob_id = 5'd12;
    #1;
    // reads see the pre-issue mapping, so the commit bypass still applies
    checks++; if (val1_out !== 32'h55 || dep1_out !== NO_DEP) begin failures++; $display("FAIL same_cycle_read: got %h/%h want %h/%h", val1_out, dep1_out, 32'h55, NO_DEP); end
    tick(); idle(); #1;
    checks++; if (val1_out !== 32'h55) begin failures++; $display("FAIL same_val x6: got %h want %h", val1_out, 32'h55); end
    checks++; if (dep2_out !== 6'h0C) begin failures++; $display("FAIL same_dep x6: got %h want %h", dep2_out, 6'h0C); end
  endtask

  task automatic test_flush();
    rename(5'd1, 5'd3);
    rename(5'd2, 5'd4);
    rename(5'd8, 5'd5);
    rs1_in = 5'd8; rs2_in = 5'd2;
    #1;
    checks++; if (dep1_out !== 6'h05) begin failures++; $display("FAIL pre_flush_dep x8: got %h want %h", dep1_out, 6'h05); end
    checks++; if (dep2_out !== 6'h04) begin failures++; $display("FAIL pre_flush_dep x2: got %h want %h", dep2_out, 6'h04); end
    flush_in = 1'b1;
    rob_valid = 1'b1; rob_rd = 5'd1; rob_dependency = 6'h03; rob_value = 32'h80;
    dec_valid = 1'b1; dec_rd = 5'd9; dec_rob_id = 5'd6;
    tick(); idle();
    rs1_in = 5'd1; rs2_in = 5'd2; #1;
    checks++; if (val1_out !== 32'h80 || dep1_out !== NO_DEP) begin failures++; $display("FAIL flush x1: got %h/%h want %h/%h", val1_out, dep1_out, 32'h80, NO_DEP); end
    checks++; if (dep2_out !== NO_DEP) begin failures++; $display("FAIL flush_dep x2: got %h want %h", dep2_out, NO_DEP); end
    rs1_in = 5'd8; rs2_in = 5'd9; #1;
    checks++; if (dep1_out !== NO_DEP) begin failures++; $display("FAIL flush_dep x8: got %h want %h", dep1_out, NO_DEP); end
    checks++; if (dep2_out !== NO_DEP) begin failures++; $display("FAIL flush_drop_rename x9: got %h want %h", dep2_out, NO_DEP); end
    rs1_in = 5'd6; #1;
    checks++; if (dep1_out !== NO_DEP || val1_out !== 32'h55) begin failures++; $display("FAIL flush x6: got %h/%h want %h/%h", val1_out, dep1_out, 32'h55, NO_DEP); end
  endtask

  task automatic test_x0();
    rs1_in = 5'd0; rs2_in = 5'd0;
    rob_valid = 1'b1; rob_rd = 5'd0; rob_dependency = NO_DEP; rob_value = 32'h1234;
    dec_valid = 1'b1; dec_rd = 5'd0; dec_rob_id = 5'd3;
    #1;
    checks++; if (val1_out !== 32'h0 || dep1_out !== NO_DEP) begin failures++; $display("FAIL x0_bypass: got %h/%h want %h/%h", val1_out, dep1_out, 32'h0, NO_DEP); end
    tick(); idle(); #1;
    checks++; if (val2_out !== 32'h0 || dep2_out !== NO_DEP) begin failures++; $display("FAIL x0_state: got %h/%h want %h/%h", val2_out, dep2_out, 32'h0, NO_DEP); end
  endtask

  task automatic test_rdy_hold();
    rename(5'd5, 5'd3);
    rdy_in = 1'b0;
    rob_valid = 1'b1; rob_rd = 5'd5; rob_dependency = 6'h03; rob_value = 32'hABCD;
    dec_valid = 1'b1; dec_rd = 5'd7; dec_rob_id = 5'd1;
    tick(); idle();
    rdy_in = 1'b1;
    rs1_in = 5'd5; rs2_in = 5'd7; #1;
    checks++; if (val1_out !== 32'h0) begin failures++; $display("FAIL hold_val x5: got %h want %h", val1_out, 32'h0); end
    checks++; if (dep1_out !== 6'h03) begin failures++; $display("FAIL hold_dep x5: got %h want %h", dep1_out, 6'h03); end
    checks++; if (dep2_out !== NO_DEP) begin failures++; $display("FAIL hold_rename x7: got %h want %h", dep2_out, NO_DEP); end
    // same commit with rdy high now lands
    rob_valid = 1'b1; rob_rd = 5'd5; rob_dependency = 6'h03; rob_value = 32'hABCD;
    tick(); idle(); #1;
    checks++; if (val1_out !== 32'hABCD || dep1_out !== NO_DEP) begin failures++; $display("FAIL rdy_commit x5: got %h/%h want %h/%h", val1_out, dep1_out, 32'hABCD, NO_DEP); end
  endtask

  initial begin
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_same_cycle();
    test_flush();
    test_x0();
    test_rdy_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_file
